// File: rtl/stall_mem_ctrl.sv
// Stalling single-port 16-bit word memory controller.
// One request at a time; fixed LATENCY from request to Done pulse.
module stall_mem_ctrl #(
    parameter int LATENCY = 4,
    parameter int AW      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] Addr,
    input  logic [15:0] DataIn,
    input  logic        Rd,
    input  logic        Wr,
    output logic [15:0] DataOut,
    output logic        Done,
    output logic        Stall,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    localparam int DEPTH = 2 ** AW;
    localparam logic [3:0] LOAD = 4'(LATENCY - 2);

    state_t          r_state;
    state_t          w_next;
    logic [3:0]      r_cnt;
    logic [3:0]      w_cnt_next;
    logic            r_op_wr;
    logic [AW-1:0]   r_addr;
    logic [15:0]     r_data;
    logic [15:0]     r_mem [DEPTH];

    logic            w_req;
    logic            w_both;
    logic            w_accept;
    logic            w_commit;
    logic            w_unused;

    assign w_req    = Rd ^ Wr;
    assign w_both   = Rd & Wr;
    assign w_unused = ^Addr;

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_accept   = 1'b0;
        w_commit   = 1'b0;
        Stall      = 1'b0;
        unique case (r_state)
            IDLE: begin
                Stall = w_req;
                if (w_req) begin
                    w_accept   = 1'b1;
                    w_next     = BUSY;
                    w_cnt_next = LOAD;
                end
            end
            BUSY: begin
                Stall = 1'b1;
                if (r_cnt == 4'd0) begin
                    w_commit = 1'b1;
                    w_next   = DONE;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
        // Reset wins over anything presented in the same cycle
        if (rst) begin
            Stall    = 1'b0;
            w_accept = 1'b0;
            w_commit = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            DataOut <= 16'h0000;
            err     <= 1'b0;
            r_op_wr <= 1'b0;
            r_addr  <= '0;
            r_data  <= 16'h0000;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 16'h0000;
            end
        end else begin
            if (w_accept) begin
                r_op_wr <= Wr;
                r_addr  <= Addr[AW:1];
                r_data  <= DataIn;
                if (Addr[0]) begin
                    err <= 1'b1;
                end
            end
            if (r_state == IDLE && w_both) begin
                err <= 1'b1;
            end
            // Writes land and reads sample on the edge into DONE
            if (w_commit) begin
                if (r_op_wr) begin
                    r_mem[r_addr] <= r_data;
                end else begin
                    DataOut <= r_mem[r_addr];
                end
            end
        end
    end

    assign Done = (r_state == DONE);

endmodule

// File: tb/tb_stall_mem_ctrl.sv
// Scoreboard bench for stall_mem_ctrl: stimulus pushes expected
// completions, a negedge monitor pops and compares.
module tb_stall_mem_ctrl;

    localparam int L  = 4;
    localparam int AW = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] Addr;
    logic [15:0] DataIn;
    logic        Rd;
    logic        Wr;
    logic [15:0] DataOut;
    logic        Done;
    logic        Stall;
    logic        err;

    stall_mem_ctrl #(.LATENCY(L), .AW(AW)) dut (
        .clk    (clk),
        .rst    (rst),
        .Addr   (Addr),
        .DataIn (DataIn),
        .Rd     (Rd),
        .Wr     (Wr),
        .DataOut(DataOut),
        .Done   (Done),
        .Stall  (Stall),
        .err    (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        bit          rd;
        logic [15:0] data;
    } exp_t;

    exp_t        q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          free_at = 0;
    logic [15:0] mem_m [2**AW];
    logic [15:0] dout_m = 16'h0000;
    logic        err_m = 1'b0;
    logic        exp_stall = 1'b0;
    logic        exp_err = 1'b0;

    function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", n, cyc, act, exp);
        end
    endfunction

    task automatic step(input logic r, input logic rd, input logic wr,
                        input logic [15:0] a, input logic [15:0] d);
        int idx;
        bit idle;
        @(posedge clk);
        #1;
        cyc++;
        rst    = r;
        Rd     = rd;
        Wr     = wr;
        Addr   = a;
        DataIn = d;
        idle = (cyc >= free_at);
        if (r) exp_stall = 1'b0;
        else if (idle) exp_stall = rd ^ wr;
        else exp_stall = (cyc <= free_at - 2);
        exp_err = err_m;
        if (r) begin
            err_m = 1'b0;
            foreach (mem_m[i]) mem_m[i] = 16'h0000;
            free_at = cyc + 1;
            while (q.size() > 0 && q[$].cyc > cyc) void'(q.pop_back());
        end else if (idle) begin
            if (rd && wr) begin
                err_m = 1'b1;
            end else if (rd ^ wr) begin
                if (a[0]) err_m = 1'b1;
                idx = (int'(a) >> 1) % (2 ** AW);
                q.push_back('{cyc + L, rd, rd ? mem_m[idx] : 16'h0000});
                if (wr) mem_m[idx] = d;
                free_at = cyc + L + 1;
            end
        end
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 16'h0000, 16'h0000);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (cyc >= 2) begin
            chk("stall", {31'd0, Stall}, {31'd0, exp_stall});
            chk("err", {31'd0, err}, {31'd0, exp_err});
            if (Done === 1'b1) begin
                if (q.size() == 0) begin
                    chk("done_unexpected", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("done_cycle", cyc, e.cyc);
                    if (e.rd) dout_m = e.data;
                end
            end else if (q.size() > 0 && q[0].cyc <= cyc) begin
                chk("done_missing", {31'd0, Done}, 32'd1);
                void'(q.pop_front());
            end
            chk("dataout", {16'd0, DataOut}, {16'd0, dout_m});
            if (rst) dout_m = 16'h0000;
        end
    end

    initial begin
        rst = 1'b1; Rd = 1'b0; Wr = 1'b0;
        Addr = 16'h0; DataIn = 16'h0;
        foreach (mem_m[i]) mem_m[i] = 16'h0000;
        repeat (3) step(1, 0, 0, 16'h0, 16'h0);
        // write/read-back
        step(0, 0, 1, 16'h0010, 16'hBEEF);
        idle_n(L);
        step(0, 1, 0, 16'h0010, 16'h0000);
        idle_n(L + 1);
        // Rd and Wr together
        step(0, 1, 1, 16'h0040, 16'h1111);
        idle_n(20);
        // misaligned write
        step(1, 0, 0, 16'h0, 16'h0);
        step(0, 0, 1, 16'h0011, 16'h1234);
        idle_n(L);
        step(0, 1, 0, 16'h0010, 16'h0000);
        idle_n(L + 1);
        // reset mid-write
        step(1, 0, 0, 16'h0, 16'h0);
        step(0, 0, 1, 16'h0002, 16'hAAAA);
        step(0, 0, 0, 16'h0, 16'h0);
        step(1, 0, 0, 16'h0, 16'h0);
        step(0, 1, 0, 16'h0002, 16'h0000);
        idle_n(L + 1);
        // address wrap
        step(0, 0, 1, 16'h0202, 16'h5A5A);
        idle_n(L);
        step(0, 1, 0, 16'h0002, 16'h0000);
        idle_n(L + 1);
        // Rd held high, address churns while busy
        for (int i = 0; i < 3 * (L + 1); i++)
            step(0, 1, 0, 16'($urandom_range(0, 15) * 2), 16'($urandom));
        idle_n(L + 1);
        // random traffic
        for (int i = 0; i < 800; i++) begin
            logic [15:0] a;
            int k;
            k = $urandom_range(0, 99);
            a = 16'($urandom_range(0, 7)) << 1;
            if ($urandom_range(0, 9) == 0) a = 16'($urandom);
            if (k < 2) step(1, 0, 0, a, 16'($urandom));
            else if (k < 5) step(0, 1, 1, a, 16'($urandom));
            else if (k < 35) step(0, 1, 0, a, 16'($urandom));
            else if (k < 65) step(0, 0, 1, a, 16'($urandom));
            else step(0, 0, 0, a, 16'($urandom));
        end
        idle_n(L + 2);
        @(negedge clk);
        #1;
        chk("queue_drained", q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
